// File: rtl/obstacle_scroller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// obstacle_scroller: LFSR-picked two-obstacle waves scrolled down per frame.
// Optional: SCROLLER_SPEEDUP_EN adds wave_count[7:3] to the step, saturating at 15.
// Revision: 1.0
// ----------------------------------------------------------------------------
module obstacle_scroller #(
  parameter logic [9:0] BOTTOM     = 10'd480,
  parameter int         GAP_FRAMES = 30,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       restart,
  input  logic       frame_tick,
  input  logic [3:0] speed,
  output logic [2:0] index,
  input  logic [9:0] rom_x0,
  input  logic [9:0] rom_y0,
  input  logic [9:0] rom_x1,
  input  logic [9:0] rom_y1,
  output logic [9:0] obs0_x,
  output logic [9:0] obs0_y,
  output logic [9:0] obs1_x,
  output logic [9:0] obs1_y,
  output logic [1:0] obs_active,
  output logic       wave_done,
  output logic [7:0] wave_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [9:0] HIDDEN_Y = 10'h26C;
  localparam int         GW       = (GAP_FRAMES < 2) ? 1 : $clog2(GAP_FRAMES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_FRAMES);

  logic [1:0]    state;
  logic [7:0]    lfsr;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_next;
  logic [2:0]    pattern;
  logic [3:0]    step;
  logic          below0;
  logic          below1;
  logic [9:0]    y0_next;
  logic [9:0]    y1_next;

  // Fold 6 and 7 back onto 0 and 1 so the ROM only needs six entries.
  always_comb begin
    pattern = lfsr[2:0];
    if (lfsr[2:0] >= 3'd6) begin
      pattern = lfsr[2:0] - 3'd6;
    end
  end

`ifdef SCROLLER_SPEEDUP_EN
  logic [5:0] boosted;
  assign boosted = {2'b00, speed} + {1'b0, wave_count[7:3]};
  assign step    = (boosted > 6'd15) ? 4'd15 : boosted[3:0];
`else
  assign step = speed;
`endif

  assign below0   = (obs0_y < BOTTOM);
  assign below1   = (obs1_y < BOTTOM);
  assign y0_next  = below0 ? (obs0_y + {6'd0, step}) : obs0_y;
  assign y1_next  = below1 ? (obs1_y + {6'd0, step}) : obs1_y;
  assign gap_next = gap_cnt + 1'b1;

  // Free-running: keeps stepping while run is low so pattern choice stays varied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      index      <= 3'd0;
      obs0_x     <= 10'd0;
      obs1_x     <= 10'd0;
      obs0_y     <= HIDDEN_Y;
      obs1_y     <= HIDDEN_Y;
      obs_active <= 2'b00;
      wave_done  <= 1'b0;
      wave_count <= 8'd0;
      gap_cnt    <= '0;
    end else begin
      wave_done <= 1'b0;
      if (restart) begin
        state      <= IDLE;
        obs0_x     <= 10'd0;
        obs1_x     <= 10'd0;
        obs0_y     <= HIDDEN_Y;
        obs1_y     <= HIDDEN_Y;
        obs_active <= 2'b00;
        wave_count <= 8'd0;
        gap_cnt    <= '0;
      end else if (run) begin
        case (state)
          IDLE: begin
            index <= pattern;
            state <= LOAD;
          end
          LOAD: begin
            obs0_x     <= rom_x0;
            obs0_y     <= rom_y0;
            obs1_x     <= rom_x1;
            obs1_y     <= rom_y1;
            obs_active <= {rom_y1 < BOTTOM, rom_y0 < BOTTOM};
            state      <= RUN;
          end
          RUN: begin
            if (!below0 && !below1) begin
              wave_done  <= 1'b1;
              wave_count <= wave_count + 8'd1;
              gap_cnt    <= '0;
              state      <= GAP;
            end else if (frame_tick) begin
              obs0_y     <= y0_next;
              obs1_y     <= y1_next;
              obs_active <= {y1_next < BOTTOM, y0_next < BOTTOM};
            end
          end
          GAP: begin
            if (frame_tick) begin
              gap_cnt <= gap_next;
              if (gap_next == GAP_LAST) begin
                index <= pattern;
                state <= LOAD;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/obstacle_scroller.md
OBSTACLE_SCROLLER -- requirements
Module: obstacle_scroller

Interface
REQ-001 SHALL have parameter BOTTOM, default 10'd480, meaning the first row past the visible field; an obstacle is active while y < BOTTOM.
REQ-002 SHALL have parameter GAP_FRAMES, default 30, meaning the number of frame ticks between the end of one wave and the load of the next.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the nonzero reset value of the pattern LFSR.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port run, input, 1; level, 1 = advance, 0 = freeze all state except the LFSR.
REQ-007 SHALL have port restart, input, 1; synchronous single-cycle abort to IDLE.
REQ-008 SHALL have port frame_tick, input, 1; one-cycle pulse per video frame.
REQ-009 SHALL have port speed, input, 4; pixels added to each active y per frame_tick.
REQ-010 SHALL have port index, output, 3; registered pattern select driven to the position ROM.
REQ-011 SHALL have ports rom_x0, rom_y0, rom_x1, rom_y1, input, 10 each; combinational ROM outputs for the current index.
REQ-012 SHALL have ports obs0_x, obs0_y, obs1_x, obs1_y, output, 10 each; registered current obstacle positions.
REQ-013 SHALL have port obs_active, output, 2; bit n = (obsn_y < BOTTOM), registered.
REQ-014 SHALL have port wave_done, output, 1; one-cycle pulse when a wave leaves the field.
REQ-015 SHALL have port wave_count, output, 8; completed waves, wraps 255 -> 0.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN, GAP.
REQ-017 LFSR SHALL be 8-bit Fibonacci, taps 8,6,5,4, stepping every cycle, including while run = 0.
REQ-018 Pattern select SHALL be p = lfsr[2:0]; if p >= 6 then p - 6 is used, so index is always in 0..5.
REQ-019 IDLE: on run = 1, index <= pattern select; next state LOAD.
REQ-020 LOAD: obs0_x/y <= rom_x0/y0 and obs1_x/y <= rom_x1/y1, exactly one cycle after index changed; next state RUN.
REQ-021 RUN: on frame_tick with run = 1, every obstacle with y < BOTTOM SHALL get y <= y + speed; obstacles with y >= BOTTOM (including the hidden marker 10'h26C) SHALL NOT move. Speed <= 15 and BOTTOM <= 1008 prevent 10-bit overflow.
REQ-022 RUN: the first cycle in which both y >= BOTTOM SHALL pulse wave_done, increment wave_count, clear the gap counter, and enter GAP.
REQ-023 GAP: the counter SHALL increment on each frame_tick with run = 1; at GAP_FRAMES, index <= pattern select and the next state is LOAD.
REQ-024 speed = 0 SHALL hold positions; the wave never ends on its own.
REQ-025 restart SHALL, in any state, force IDLE, both y to 10'h26C, both x to 0, obs_active to 0 and wave_count to 0; it SHALL NOT reset the LFSR, and restart wins over a simultaneous frame_tick.
REQ-026 run = 0 SHALL block every transition and update except the LFSR step; frame_tick is ignored while run = 0.
REQ-027 obs_active SHALL be updated in the same cycle as the y registers.

Reset
REQ-028 rst_n = 0 SHALL asynchronously set: state IDLE, index 0, obs0_x = obs1_x = 0, obs0_y = obs1_y = 10'h26C, obs_active 0, wave_done 0, wave_count 0, gap counter 0, lfsr LFSR_SEED.
REQ-029 Reset deassertion mid-wave SHALL resume from IDLE; no partial wave is kept.

Configuration
REQ-030 With SCROLLER_SPEEDUP_EN defined, the effective speed SHALL be min(speed + wave_count[7:3], 15), i.e. +1 per 8 waves, saturating.
REQ-031 Without SCROLLER_SPEEDUP_EN, the effective speed SHALL be speed unchanged and no extra logic is synthesised.

Verification
REQ-032 Reset, run = 1, ROM model from 6-entry table: index = 5 (A5 -> p = 5); one cycle later obs0 = (0x117, 0), obs1 = (0x169, 0x26C), obs_active = 01.
REQ-033 speed = 8, BOTTOM = 480, frame_tick every 4 cycles: wave_done pulses on the 60th tick, wave_count = 1, obs1_y stays 0x26C throughout.
REQ-034 GAP_FRAMES = 30: new index is issued exactly at the 30th tick after wave_done, and positions load one cycle later.
REQ-035 restart asserted together with frame_tick in RUN: next cycle state is IDLE, both y = 0x26C, wave_count = 0.
REQ-036 run dropped for 100 cycles with ticks mid-RUN: positions unchanged; on resume, motion continues from the held values.
REQ-037 With SCROLLER_SPEEDUP_EN, speed = 14, after 16 waves: effective step = 15 (saturated); without the macro: step = 14.
